// File: rtl/ctrl_decode_pipe_pkg.sv
// RV32I/RV32M control-word types shared by the decoder and the control pipeline.
// Includes the NOP control word and the multi-cycle M-op FSM state type.
package ctrl_decode_pipe_pkg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
    alu_xor = 3'b100, alu_srl = 3'b101, alu_or  = 3'b110, alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    beq = 3'b000, bne = 3'b001, blt = 3'b100, bge = 3'b101, bltu = 3'b110, bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    md_mul = 3'b000, md_mulh = 3'b001, md_mulhsu = 3'b010, md_mulhu = 3'b011,
    md_div = 3'b100, md_divu = 3'b101, md_rem = 3'b110, md_remu = 3'b111
  } muldiv_funct3_t;

  typedef enum logic [1:0] {pc_plus4, pc_alu_out, pc_alu_mod2} pcmux_sel_t;
  typedef enum logic {a1_rs1, a1_pc} alumux1_sel_t;
  typedef enum logic [2:0] {a2_i_imm, a2_u_imm, a2_b_imm, a2_s_imm, a2_j_imm, a2_rs2} alumux2_sel_t;
  typedef enum logic {cmp_rs2, cmp_i_imm} cmpmux_sel_t;
  typedef enum logic [3:0] {
    rf_alu_out, rf_br_en, rf_u_imm, rf_lw, rf_pc_plus4, rf_lb, rf_lbu, rf_lh, rf_lhu
  } regfilemux_sel_t;

  typedef enum logic {IDLE, BUSY} muldiv_state_t;

  typedef struct packed {
    rv32i_opcode     opcode;
    logic [31:0]     pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    alu_ops          aluop;
    branch_funct3_t  cmpop;
    alumux1_sel_t    alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    cmpmux_sel_t     cmpmux_sel;
    regfilemux_sel_t regfilemux_sel;
    pcmux_sel_t      pcmux_sel;
    logic            load_regfile;
    logic            mem_read;
    logic            mem_write;
    logic            illegal;
    logic            is_muldiv;
  } rv32i_control_word;

  localparam rv32i_control_word CTRL_NOP = '{
    opcode: op_imm, pc: 32'h0, rd: 5'h0, rs1: 5'h0, rs2: 5'h0, funct3: 3'h0,
    aluop: alu_add, cmpop: beq, alumux1_sel: a1_rs1, alumux2_sel: a2_i_imm,
    cmpmux_sel: cmp_rs2, regfilemux_sel: rf_alu_out, pcmux_sel: pc_plus4,
    load_regfile: 1'b0, mem_read: 1'b0, mem_write: 1'b0, illegal: 1'b0, is_muldiv: 1'b0
  };

endpackage

// File: rtl/ctrl_decode_pipe_decode.sv
// Combinational RV32I (+ optional RV32M, macro CTRL_MULDIV_EN) instruction decoder.
// Illegal encodings collapse to the NOP word with illegal set.
module ctrl_decode
  import ctrl_decode_pipe_pkg::*;
(
  input  logic [31:0]       instr,
  input  logic [31:0]       pc,
  output rv32i_control_word ctrl
);

  logic [2:0] f3;
  logic [6:0] f7;
  logic       bad;

  assign f3 = instr[14:12];
  assign f7 = instr[31:25];

  always_comb begin
    ctrl        = CTRL_NOP;
    bad         = 1'b0;
    ctrl.opcode = rv32i_opcode'(instr[6:0]);
    ctrl.pc     = pc;
    ctrl.rd     = instr[11:7];
    ctrl.rs1    = instr[19:15];
    ctrl.rs2    = instr[24:20];
    ctrl.funct3 = f3;
    case (instr[6:0])
      op_lui: begin
        ctrl.load_regfile   = 1'b1;
        ctrl.regfilemux_sel = rf_u_imm;
      end
      op_auipc: begin
        ctrl.alumux1_sel  = a1_pc;
        ctrl.alumux2_sel  = a2_u_imm;
        ctrl.load_regfile = 1'b1;
      end
      op_jal: begin
        ctrl.alumux1_sel    = a1_pc;
        ctrl.alumux2_sel    = a2_j_imm;
        ctrl.pcmux_sel      = pc_alu_out;
        ctrl.load_regfile   = 1'b1;
        ctrl.regfilemux_sel = rf_pc_plus4;
      end
      op_jalr: begin
        ctrl.pcmux_sel      = pc_alu_mod2;
        ctrl.load_regfile   = 1'b1;
        ctrl.regfilemux_sel = rf_pc_plus4;
      end
      op_br: begin
        bad              = (f3 == 3'd2) || (f3 == 3'd3);
        ctrl.alumux1_sel = a1_pc;
        ctrl.alumux2_sel = a2_b_imm;
        ctrl.cmpop       = branch_funct3_t'(f3);
      end
      op_load: begin
        ctrl.mem_read     = 1'b1;
        ctrl.load_regfile = 1'b1;
        case (f3)
          3'b000:  ctrl.regfilemux_sel = rf_lb;
          3'b001:  ctrl.regfilemux_sel = rf_lh;
          3'b010:  ctrl.regfilemux_sel = rf_lw;
          3'b100:  ctrl.regfilemux_sel = rf_lbu;
          3'b101:  ctrl.regfilemux_sel = rf_lhu;
          default: bad = 1'b1;
        endcase
      end
      op_store: begin
        bad              = (f3 > 3'd2);
        ctrl.mem_write   = 1'b1;
        ctrl.alumux2_sel = a2_s_imm;
      end
      op_imm, op_reg: begin
        ctrl.load_regfile = 1'b1;
        if (instr[5]) ctrl.alumux2_sel = a2_rs2;
        if (instr[5] && (f7 == 7'b0000001)) begin
`ifdef CTRL_MULDIV_EN
          ctrl.is_muldiv = 1'b1;
          ctrl.aluop     = alu_ops'(muldiv_funct3_t'(f3));
`else
          bad = 1'b1;
`endif
        end else begin
          case (f3)
            3'b000: ctrl.aluop = (instr[5] && f7[5]) ? alu_sub : alu_add;
            3'b010, 3'b011: begin
              ctrl.cmpop          = (f3 == 3'b010) ? blt : bltu;
              ctrl.cmpmux_sel     = instr[5] ? cmp_rs2 : cmp_i_imm;
              ctrl.regfilemux_sel = rf_br_en;
            end
            3'b101:  ctrl.aluop = f7[5] ? alu_sra : alu_srl;
            default: ctrl.aluop = alu_ops'(f3);
          endcase
        end
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      ctrl         = CTRL_NOP;
      ctrl.pc      = pc;
      ctrl.illegal = 1'b1;
    end
    if (ctrl.rd == 5'd0) ctrl.load_regfile = 1'b0;
  end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// CTRL_STAGES-deep registered control pipeline fed by ctrl_decode, with stall/flush/bubble
// handling and an optional multi-cycle M-op hold FSM enabled by macro CTRL_MULDIV_EN.
module ctrl_decode_pipe
  import ctrl_decode_pipe_pkg::*;
#(
  parameter int CTRL_STAGES = 3,
  parameter int MULDIV_LAT  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_valid,
  input  logic [31:0]            instr,
  input  logic [31:0]            pc,
  input  logic                   stall_in,
  input  logic                   flush_in,
  output logic                   stall_out,
  output rv32i_control_word      ctrl_out [CTRL_STAGES],
  output logic [CTRL_STAGES-1:0] valid_out,
  output logic                   muldiv_start,
  output muldiv_state_t          dbg_state
);

  // Handshake: fetch must hold instr/pc/instr_valid while stall_out=1; any stage moves only when stall_in=0.

  rv32i_control_word      dec_ctrl;
  rv32i_control_word      ctrl_q [CTRL_STAGES];
  rv32i_control_word      ctrl_d [CTRL_STAGES];
  logic [CTRL_STAGES-1:0] valid_q, valid_d;
  logic                   hold;

  ctrl_decode u_decode (
    .instr (instr),
    .pc    (pc),
    .ctrl  (dec_ctrl)
  );

`ifdef CTRL_MULDIV_EN
  localparam int CNT_W = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic             pending, release_m;

  always_comb begin
    pending   = (MULDIV_LAT > 1) && valid_q[0] && ctrl_q[0].is_muldiv;
    release_m = (state_q == BUSY) && (cnt_q == '0) && !stall_in;
    hold      = ((state_q == IDLE) && pending) || ((state_q == BUSY) && !release_m);
    state_d   = state_q;
    cnt_d     = cnt_q;
    start_d   = 1'b0;
    if (!stall_in) begin
      if (flush_in) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (state_q == IDLE) begin
        // Entry cycle is itself a hold cycle, so the remaining count is LAT-2.
        if (pending) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(MULDIV_LAT - 2);
          start_d = 1'b1;
        end
      end else if (release_m) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
    end
  end

  assign muldiv_start = start_q;
  assign dbg_state    = state_q;
`else
  assign hold         = 1'b0;
  assign muldiv_start = 1'b0;
  assign dbg_state    = IDLE;
`endif

  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    if (!stall_in) begin
      if (flush_in) begin
        ctrl_d[0]  = CTRL_NOP;
        valid_d[0] = 1'b0;
      end else if (!hold) begin
        ctrl_d[0]  = instr_valid ? dec_ctrl : CTRL_NOP;
        valid_d[0] = instr_valid;
      end
      // A held stage 0 feeds a bubble into stage 1; deeper stages drain normally.
      for (int k = 1; k < CTRL_STAGES; k++) begin
        if ((k == 1) && hold) begin
          ctrl_d[k]  = CTRL_NOP;
          valid_d[k] = 1'b0;
        end else begin
          ctrl_d[k]  = ctrl_q[k-1];
          valid_d[k] = valid_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < CTRL_STAGES; k++) ctrl_q[k] <= CTRL_NOP;
      valid_q <= '0;
    end else begin
      for (int k = 0; k < CTRL_STAGES; k++) ctrl_q[k] <= ctrl_d[k];
      valid_q <= valid_d;
    end
  end

  assign ctrl_out  = ctrl_q;
  assign valid_out = valid_q;
  assign stall_out = stall_in || hold;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench for ctrl_decode_pipe: decode table, pipeline shift, stall, flush and M-op hold.
module tb_ctrl_decode_pipe;
  import ctrl_decode_pipe_pkg::*;

  localparam int CTRL_STAGES = 3;
  localparam int MULDIV_LAT  = 4;
  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_MUL  = 32'h027302B3;

  logic                   clk = 1'b0;
  logic                   rst, instr_valid, stall_in, flush_in;
  logic [31:0]            instr, pc;
  logic                   stall_out, muldiv_start;
  rv32i_control_word      ctrl_out [CTRL_STAGES];
  logic [CTRL_STAGES-1:0] valid_out;
  muldiv_state_t          dbg_state;
  int                     checks = 0;
  int                     failures = 0;

  ctrl_decode_pipe #(.CTRL_STAGES(CTRL_STAGES), .MULDIV_LAT(MULDIV_LAT)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .pc(pc),
    .stall_in(stall_in), .flush_in(flush_in), .stall_out(stall_out),
    .ctrl_out(ctrl_out), .valid_out(valid_out), .muldiv_start(muldiv_start),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    checks++; failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // driver tasks
  task automatic cyc;
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p);
    instr_valid = v; instr = i; pc = p;
  endtask

  task automatic drain;
    drive(1'b0, 32'h0, 32'h0); stall_in = 1'b0; flush_in = 1'b0;
    repeat (4) cyc;
  endtask

  task automatic test_reset;
    rst = 1'b0; stall_in = 1'b0; flush_in = 1'b0; drive(1'b1, I_ADDI, 32'h40);
    cyc; cyc;
    checks++; if (valid_out !== 3'b000) begin failures++; $display("FAIL reset_valid got=%b exp=000", valid_out); end
    checks++; if (ctrl_out[0] !== CTRL_NOP) begin failures++; $display("FAIL reset_ctrl0 got=%h exp=%h", ctrl_out[0], CTRL_NOP); end
    checks++; if (ctrl_out[2] !== CTRL_NOP) begin failures++; $display("FAIL reset_ctrl2 got=%h exp=%h", ctrl_out[2], CTRL_NOP); end
    checks++; if ({stall_out, muldiv_start} !== 2'b00) begin failures++; $display("FAIL reset_stall_start got=%b exp=00", {stall_out, muldiv_start}); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
    drive(1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    cyc;
  endtask

  task automatic test_addi;
    drive(1'b1, I_ADDI, 32'h100); cyc; drive(1'b0, 32'h0, 32'h0);
    checks++; if (valid_out !== 3'b001) begin failures++; $display("FAIL addi_valid0 got=%b exp=001", valid_out); end
    checks++; if (ctrl_out[0].aluop !== alu_add) begin failures++; $display("FAIL addi_aluop got=%0d exp=%0d", ctrl_out[0].aluop, alu_add); end
    checks++; if (ctrl_out[0].alumux2_sel !== a2_i_imm) begin failures++; $display("FAIL addi_alumux2 got=%0d exp=%0d", ctrl_out[0].alumux2_sel, a2_i_imm); end
    checks++; if ({ctrl_out[0].load_regfile, ctrl_out[0].rd} !== {1'b1, 5'd1}) begin failures++; $display("FAIL addi_lr_rd got=%b/%0d exp=1/1", ctrl_out[0].load_regfile, ctrl_out[0].rd); end
    checks++; if (ctrl_out[0].pc !== 32'h100) begin failures++; $display("FAIL addi_pc got=%h exp=100", ctrl_out[0].pc); end
    cyc; cyc;
    checks++; if (valid_out !== 3'b100) begin failures++; $display("FAIL addi_valid2 got=%b exp=100", valid_out); end
    checks++; if ({ctrl_out[2].pc, ctrl_out[2].load_regfile} !== {32'h100, 1'b1}) begin failures++; $display("FAIL addi_stage2 got=%h/%b exp=100/1", ctrl_out[2].pc, ctrl_out[2].load_regfile); end
  endtask

  task automatic test_alu_ops;
    logic [31:0]     ins [8];
    alu_ops          alu [8];
    alumux2_sel_t    m2  [8];
    regfilemux_sel_t rf  [8];
    pcmux_sel_t      pcm [8];
    logic [2:0]      lrw [8];
    // sub, srai, addi(bit30), slti, lw, sw, and, jal
    ins = '{32'h402081B3, 32'h4030D213, 32'h40008293, 32'h0010A313, 32'h0040A383, 32'h0020A423, 32'h0020F433, 32'h000000EF};
    alu = '{alu_sub, alu_sra, alu_add, alu_add, alu_add, alu_add, alu_and, alu_add};
    m2  = '{a2_rs2, a2_i_imm, a2_i_imm, a2_i_imm, a2_i_imm, a2_s_imm, a2_rs2, a2_j_imm};
    rf  = '{rf_alu_out, rf_alu_out, rf_alu_out, rf_br_en, rf_lw, rf_alu_out, rf_alu_out, rf_pc_plus4};
    pcm = '{pc_plus4, pc_plus4, pc_plus4, pc_plus4, pc_plus4, pc_plus4, pc_plus4, pc_alu_out};
    lrw = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b110, 3'b001, 3'b100, 3'b100};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, ins[i], 32'h1000 + 32'(i * 4)); cyc;
      checks++; if (ctrl_out[0].aluop !== alu[i]) begin failures++; $display("FAIL alu_aluop[%0d] got=%0d exp=%0d", i, ctrl_out[0].aluop, alu[i]); end
      checks++; if (ctrl_out[0].alumux2_sel !== m2[i]) begin failures++; $display("FAIL alu_mux2[%0d] got=%0d exp=%0d", i, ctrl_out[0].alumux2_sel, m2[i]); end
      checks++; if (ctrl_out[0].regfilemux_sel !== rf[i]) begin failures++; $display("FAIL alu_rfmux[%0d] got=%0d exp=%0d", i, ctrl_out[0].regfilemux_sel, rf[i]); end
      checks++; if (ctrl_out[0].pcmux_sel !== pcm[i]) begin failures++; $display("FAIL alu_pcmux[%0d] got=%0d exp=%0d", i, ctrl_out[0].pcmux_sel, pcm[i]); end
      checks++; if ({ctrl_out[0].load_regfile, ctrl_out[0].mem_read, ctrl_out[0].mem_write} !== lrw[i]) begin failures++; $display("FAIL alu_lrw[%0d] got=%b exp=%b", i, {ctrl_out[0].load_regfile, ctrl_out[0].mem_read, ctrl_out[0].mem_write}, lrw[i]); end
    end
    drive(1'b0, 32'h0, 32'h0);
    checks++; if ({ctrl_out[2].mem_write, ctrl_out[2].pc} !== {1'b1, 32'h1014}) begin failures++; $display("FAIL b2b_stage2 got=%b/%h exp=1/1014", ctrl_out[2].mem_write, ctrl_out[2].pc); end
    checks++; if (ctrl_out[0].cmpop !== beq || ctrl_out[1].aluop !== alu_and) begin failures++; $display("FAIL b2b_stage01 got=%0d/%0d exp=%0d/%0d", ctrl_out[0].cmpop, ctrl_out[1].aluop, beq, alu_and); end
  endtask

  task automatic test_illegal;
    logic [31:0] ins [4];
    logic [3:0]  exp [4];
    // {illegal, load_regfile, mem_read, valid}
    ins = '{32'h0000007F, 32'h0040B383, 32'h00002063, 32'h00208033};
    exp = '{4'b1001, 4'b1001, 4'b1001, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ins[i], 32'h2000); cyc;
      checks++; if ({ctrl_out[0].illegal, ctrl_out[0].load_regfile, ctrl_out[0].mem_read, valid_out[0]} !== exp[i]) begin
        failures++; $display("FAIL illegal[%0d] got=%b exp=%b", i, {ctrl_out[0].illegal, ctrl_out[0].load_regfile, ctrl_out[0].mem_read, valid_out[0]}, exp[i]);
      end
    end
    drive(1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_stall;
    drain;
    drive(1'b1, I_ADDI, 32'h200); cyc;
    stall_in = 1'b1; drive(1'b1, I_SUB, 32'h204); #1;
    checks++; if (stall_out !== 1'b1) begin failures++; $display("FAIL stall_out got=%b exp=1", stall_out); end
    cyc; cyc;
    checks++; if ({valid_out, ctrl_out[0].pc} !== {3'b001, 32'h200}) begin failures++; $display("FAIL stall_freeze got=%b/%h exp=001/200", valid_out, ctrl_out[0].pc); end
    stall_in = 1'b0; cyc;
    checks++; if ({valid_out, ctrl_out[0].pc, ctrl_out[1].pc} !== {3'b011, 32'h204, 32'h200}) begin failures++; $display("FAIL stall_resume got=%b/%h/%h exp=011/204/200", valid_out, ctrl_out[0].pc, ctrl_out[1].pc); end
  endtask

  task automatic test_flush_idle;
    drive(1'b1, I_ADDI, 32'h300); flush_in = 1'b1; cyc;
    flush_in = 1'b0; drive(1'b0, 32'h0, 32'h0);
    checks++; if (valid_out !== 3'b110) begin failures++; $display("FAIL flush_valid got=%b exp=110", valid_out); end
    checks++; if (ctrl_out[0] !== CTRL_NOP) begin failures++; $display("FAIL flush_ctrl0 got=%h exp=%h", ctrl_out[0], CTRL_NOP); end
    checks++; if (ctrl_out[1].pc !== 32'h204) begin failures++; $display("FAIL flush_stage1 got=%h exp=204", ctrl_out[1].pc); end
  endtask

`ifdef CTRL_MULDIV_EN
  task automatic run_mop(input int s_from, input int s_to, output int n_stall, output int n_start,
                         output int n_occ, output int n_busy, output int first_s1);
    drain;
    drive(1'b1, I_MUL, 32'h400); cyc;
    drive(1'b1, I_ADDI, 32'h404);
    n_stall = 0; n_start = 0; n_occ = 0; n_busy = 0; first_s1 = -1;
    for (int c = 0; c < 12; c++) begin
      stall_in = (c >= s_from) && (c <= s_to); #1;
      if (stall_out) n_stall++;
      if (muldiv_start) n_start++;
      if (valid_out[0] && ctrl_out[0].is_muldiv) n_occ++;
      if (dbg_state == BUSY) n_busy++;
      if (first_s1 < 0 && valid_out[1] && ctrl_out[1].is_muldiv) first_s1 = c;
      cyc;
    end
    stall_in = 1'b0; drive(1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_muldiv;
    int ns, nst, no, nb, f1;
    run_mop(99, -1, ns, nst, no, nb, f1);
    checks++; if (nst !== 1) begin failures++; $display("FAIL md_start got=%0d exp=1", nst); end
    checks++; if (ns !== 3) begin failures++; $display("FAIL md_stall got=%0d exp=3", ns); end
    checks++; if (no !== 4) begin failures++; $display("FAIL md_occ got=%0d exp=4", no); end
    checks++; if (nb !== 3) begin failures++; $display("FAIL md_busy got=%0d exp=3", nb); end
    checks++; if (f1 !== 4) begin failures++; $display("FAIL md_stage1 got=%0d exp=4", f1); end
  endtask

  task automatic test_muldiv_stall;
    int ns, nst, no, nb, f1;
    run_mop(2, 3, ns, nst, no, nb, f1);
    checks++; if (nst !== 1) begin failures++; $display("FAIL mds_start got=%0d exp=1", nst); end
    checks++; if (ns !== 5) begin failures++; $display("FAIL mds_stall got=%0d exp=5", ns); end
    checks++; if (no !== 6) begin failures++; $display("FAIL mds_occ got=%0d exp=6", no); end
    checks++; if (nb !== 5) begin failures++; $display("FAIL mds_busy got=%0d exp=5", nb); end
    checks++; if (f1 !== 6) begin failures++; $display("FAIL mds_stage1 got=%0d exp=6", f1); end
  endtask

  task automatic test_flush_busy;
    int n;
    drain;
    drive(1'b1, I_MUL, 32'h500); cyc; drive(1'b0, 32'h0, 32'h0); cyc;
    checks++; if ({dbg_state, stall_out} !== {BUSY, 1'b1}) begin failures++; $display("FAIL fb_busy got=%0d/%b exp=%0d/1", dbg_state, stall_out, BUSY); end
    flush_in = 1'b1; cyc; flush_in = 1'b0; #1;
    checks++; if ({valid_out[1:0], ctrl_out[0].is_muldiv} !== 3'b000) begin failures++; $display("FAIL fb_stages got=%b exp=000", {valid_out[1:0], ctrl_out[0].is_muldiv}); end
    checks++; if ({dbg_state, stall_out} !== {IDLE, 1'b0}) begin failures++; $display("FAIL fb_idle got=%0d/%b exp=%0d/0", dbg_state, stall_out, IDLE); end
    n = 0;
    for (int c = 0; c < 6; c++) begin if (muldiv_start) n++; cyc; end
    checks++; if (n !== 0) begin failures++; $display("FAIL fb_nostart got=%0d exp=0", n); end
  endtask

  task automatic test_reset_mid_mop;
    int n;
    drain;
    drive(1'b1, I_MUL, 32'h600); cyc; drive(1'b0, 32'h0, 32'h0); cyc;
    checks++; if (muldiv_start !== 1'b1) begin failures++; $display("FAIL rm_pulse got=%b exp=1", muldiv_start); end
    rst = 1'b0; cyc; #1;
    checks++; if ({muldiv_start, stall_out, valid_out, dbg_state} !== {1'b0, 1'b0, 3'b000, IDLE}) begin
      failures++; $display("FAIL rm_reset got=%b%b%b%0d exp=00000", muldiv_start, stall_out, valid_out, dbg_state);
    end
    rst = 1'b1; n = 0;
    for (int c = 0; c < 6; c++) begin cyc; if (muldiv_start || stall_out) n++; end
    checks++; if (n !== 0) begin failures++; $display("FAIL rm_quiet got=%0d exp=0", n); end
  endtask
`else
  task automatic test_muldiv_disabled;
    drain;
    drive(1'b1, I_MUL, 32'h400); cyc; drive(1'b0, 32'h0, 32'h0);
    checks++; if ({ctrl_out[0].illegal, ctrl_out[0].is_muldiv, valid_out[0]} !== 3'b101) begin failures++; $display("FAIL mdoff_decode got=%b exp=101", {ctrl_out[0].illegal, ctrl_out[0].is_muldiv, valid_out[0]}); end
    checks++; if ({stall_out, muldiv_start} !== 2'b00) begin failures++; $display("FAIL mdoff_stall got=%b exp=00", {stall_out, muldiv_start}); end
    stall_in = 1'b1; #1;
    checks++; if (stall_out !== 1'b1) begin failures++; $display("FAIL mdoff_passthru got=%b exp=1", stall_out); end
    stall_in = 1'b0; cyc;
  endtask
`endif

  initial begin
    test_reset;
    test_addi;
    test_alu_ops;
    test_illegal;
    test_stall;
    test_flush_idle;
`ifdef CTRL_MULDIV_EN
    test_muldiv;
    test_muldiv_stall;
    test_flush_busy;
    test_reset_mid_mop;
`else
    test_muldiv_disabled;
`endif
    // report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
